// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED definitions used by the encoder, the decoder and the
// receive buffer. It holds the syndrome width helper, the error classification
// and the flag layout of a buffered entry.
package hamming_pkg;

  // Flag bits stored next to the data word in every buffered entry: {db, sb_fix}.
  localparam int ENTRY_FLAG_BITS = 2;

  // Classification of a decoded word. A double-bit error takes priority over a single-bit error.
  typedef enum logic [1:0] {
    CLS_CLEAN = 2'd0,
    CLS_SB    = 2'd1,
    CLS_DB    = 2'd2
  } err_class_t;

  // Number of Hamming parity bits for k information bits.
  // This is the smallest m that satisfies 2^m >= k + m + 1.
  function automatic int calculate_m(input int k);
    int m;
    m = 0;
    for (int i = 1; i < 32; i++) begin
      if (m == 0 && (1 << i) >= (k + i + 1)) begin
        m = i;
      end
    end
    return m;
  endfunction

  // Width of a buffered entry {q, db, sb_fix} for k information bits.
  function automatic int entry_width(input int k);
    return k + ENTRY_FLAG_BITS;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Synchronous first-in first-out buffer with a combinational head read.
// The pointers wrap modulo DEPTH, so DEPTH must be a power of two.
// A push while full and a pop while empty are both ignored.
module hamming_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  // Storage write. The memory contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping. A reset flushes every stored word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hamming_rx_buffer.sv
// Elastic output stage behind the Hamming SECDED decoder. Each decoded word is
// classified, queued and presented on a valid/ready stream. Saturating error
// statistics and the syndrome of the last erroneous word are kept for software.
// Build option: define HAMMING_DROP_DB_EN to discard double-bit words instead of
// queueing them. Discarded words are counted in drop_cnt_o.
module hamming_rx_buffer
  import hamming_pkg::*;
#(
  parameter int K     = 8,
  parameter int M     = calculate_m(K),
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [K-1:0]               in_q_i,
  input  logic [M-1:0]               in_syndrome_i,
  input  logic                       in_sb_err_i,
  input  logic                       in_db_err_i,
  input  logic                       in_sb_fix_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [K-1:0]               out_q_o,
  output logic                       out_err_o,
  output logic                       out_fix_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           sb_cnt_o,
  output logic [CNT_W-1:0]           db_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [M-1:0]               last_syndrome_o,
  input  logic                       clr_cnt_i
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = entry_width(K);

  typedef struct packed {
    logic [K-1:0] q;
    logic         db;
    logic         sb_fix;
  } entry_t;

  err_class_t    err_class;
  entry_t        wr_entry;
  entry_t        head_entry;
  entry_t        held_entry;
  entry_t        shown_entry;
  logic [EW-1:0] head_bits;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          in_ready;
  logic          accept;
  logic          is_sb;
  logic          is_db;
  logic          push;
  logic          pop;

  // Classify the incoming word. A double-bit error overrides the single-bit flag.
  always_comb begin
    err_class = CLS_CLEAN;
    if (in_db_err_i) begin
      err_class = CLS_DB;
    end else if (in_sb_err_i) begin
      err_class = CLS_SB;
    end
  end

  assign accept = in_valid_i & in_ready;
  assign is_sb  = accept & (err_class == CLS_SB);
  assign is_db  = accept & (err_class == CLS_DB);
  assign pop    = ~fifo_empty & out_ready_i;

`ifdef HAMMING_DROP_DB_EN
  assign push = accept & ~is_db & ~fifo_full;
`else
  assign push = accept & ~fifo_full;
`endif

  assign wr_entry = '{q: in_q_i, db: in_db_err_i, sb_fix: in_sb_fix_i};

  hamming_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .pop      (pop),
    .data_in  (wr_entry),
    .data_out (head_bits),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign head_entry = entry_t'(head_bits);

  // Occupancy after this edge. It decides whether another word fits next cycle.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  // Registered ready. It stays low through reset, then tracks the next-cycle not-full state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= (level_next != LW'(DEPTH));
    end
  end

  // Remember the last popped entry so the outputs hold steady while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_entry <= '0;
    end else if (pop) begin
      held_entry <= head_entry;
    end
  end

  assign shown_entry = fifo_empty ? held_entry : head_entry;

  assign in_ready_o  = in_ready;
  assign out_valid_o = ~fifo_empty;
  assign out_q_o     = shown_entry.q;
  assign out_err_o   = shown_entry.db;
  assign out_fix_o   = shown_entry.sb_fix;
  assign level_o     = level;

  // Single-bit statistics. The counter saturates, and a clear wins over a simultaneous event.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      sb_cnt_o <= '0;
    end else if (is_sb && (sb_cnt_o != '1)) begin
      sb_cnt_o <= sb_cnt_o + CNT_W'(1);
    end
  end

  // Double-bit statistics. The counter saturates, and a clear wins over a simultaneous event.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      db_cnt_o <= '0;
    end else if (is_db && (db_cnt_o != '1)) begin
      db_cnt_o <= db_cnt_o + CNT_W'(1);
    end
  end

  // Syndrome of the most recent accepted erroneous word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      last_syndrome_o <= '0;
    end else if (is_sb || is_db) begin
      last_syndrome_o <= in_syndrome_i;
    end
  end

`ifdef HAMMING_DROP_DB_EN
  // Dropped-word statistics. Every double-bit word is discarded, so this counter advances together with db_cnt_o.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      drop_cnt_o <= '0;
    end else if (is_db && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end
`else
  assign drop_cnt_o = '0;
`endif

endmodule
